// File: rtl/sfb_pkg.sv
// sfb_pkg: shared sizes and types for the sample frame buffer.
//   FRAME_LEN  samples per frame (256)
//   SAMPLE_W   bits per sample (8)
//   PTR_W      write pointer width (8)
//   sample_t   one unsigned sample
//   frame_t    full frame, index 0 = oldest sample
package sfb_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SAMPLE_W  = 8;
  localparam int PTR_W     = 8;

  // Last write index of a frame; a transfer here completes the frame.
  localparam logic [PTR_W-1:0] PTR_LAST = 8'hFF;
  localparam logic [PTR_W-1:0] PTR_ZERO = 8'h00;
  localparam logic [PTR_W-1:0] PTR_ONE  = 8'h01;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [0:FRAME_LEN-1] frame_t;

endpackage

// File: rtl/sfb_bank.sv
// sfb_bank: one FRAME_LEN x SAMPLE_W register bank.
// Optional feature macro: SFB_FLUSH_EN (adds the synchronous zero-pad port).
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low clear of every entry
//   we        write enable for one entry
//   addr      write index
//   data      write data
//   pad_en    (SFB_FLUSH_EN) zero every entry with index >= pad_from
//   pad_from  (SFB_FLUSH_EN) first index to zero; 9 bits so 256 means "none"
//   q         whole bank, index 0 = oldest sample
module sfb_bank
  import sfb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] addr,
  input  sample_t          data,
`ifdef SFB_FLUSH_EN
  input  logic             pad_en,
  input  logic [PTR_W:0]   pad_from,
`endif
  output frame_t           q
);

  localparam int PAD_W = PTR_W + 1;

  frame_t mem_r;

  // Storage: single-entry write plus optional tail zero-pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= {(FRAME_LEN*SAMPLE_W){1'b0}};
    end else begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (we && (addr == PTR_W'(i))) begin
          mem_r[i] <= data;
        end
`ifdef SFB_FLUSH_EN
        // The written entry always sits below pad_from, so the two never collide.
        if (pad_en && (PAD_W'(i) >= pad_from)) begin
          mem_r[i] <= {SAMPLE_W{1'b0}};
        end
`endif
      end
    end
  end

  assign q = mem_r;

endmodule

// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: streaming-to-frame front end for the FIR low-pass stage.
// Samples arrive on a valid/ready stream and are packed into 256-sample frames
// in a ping-pong pair of register banks. A completed frame is swapped onto
// frame_o with a one-cycle start_flg while the other bank keeps capturing.
// Optional feature macro: SFB_FLUSH_EN (adds flush: zero-pad and launch a partial frame).
// Parameter:
//   HOLD_CYC   minimum clocks between start pulses (0 behaves as 1)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    unsigned input sample
//   in_valid   in_data valid this cycle
//   in_ready   buffer can accept (combinational from the write bank full flag)
//   start_flg  one-cycle pulse: a new frame is on frame_o
//   frame_o    presented frame, index 0 = oldest sample
//   frame_cnt  frames launched since reset, wraps
//   flush      (SFB_FLUSH_EN) zero-pad and launch the partial frame
module sample_frame_buffer
  import sfb_pkg::*;
#(
  parameter int HOLD_CYC = 4
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  sample_t     in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        start_flg,
  output frame_t      frame_o,
  output logic [15:0] frame_cnt
`ifdef SFB_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int HOLD_W   = $clog2(HOLD_EFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  // wbank_r = 0: bank A captures, bank B is presented (and vice versa).
  logic              wbank_r;
  logic [1:0]        full_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              start_r;
  logic [15:0]       frame_cnt_r;

  logic   full_w_s;
  logic   xfer_s;
  logic   swap_s;
  logic   fill_s;
  logic   flush_go_s;
  frame_t bank_a_q_s;
  frame_t bank_b_q_s;

  assign full_w_s = full_r[wbank_r];
  assign in_ready = !full_w_s;
  assign xfer_s   = in_valid && !full_w_s;
  // full and a nonzero hold are the only things that delay a swap.
  assign swap_s   = full_w_s && (hold_cnt_r == HOLD_ZERO);

`ifdef SFB_FLUSH_EN
  logic [PTR_W:0] pad_from_s;
  // A same-cycle sample counts as part of the partial frame before padding.
  assign flush_go_s = flush && !full_w_s && ((wr_ptr_r != PTR_ZERO) || xfer_s);
  assign pad_from_s = {1'b0, wr_ptr_r} + {{PTR_W{1'b0}}, xfer_s};
`else
  assign flush_go_s = 1'b0;
`endif

  assign fill_s = (xfer_s && (wr_ptr_r == PTR_LAST)) || flush_go_s;

  sfb_bank u_bank_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (xfer_s && !wbank_r),
    .addr     (wr_ptr_r),
    .data     (in_data),
`ifdef SFB_FLUSH_EN
    .pad_en   (flush_go_s && !wbank_r),
    .pad_from (pad_from_s),
`endif
    .q        (bank_a_q_s)
  );

  sfb_bank u_bank_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (xfer_s && wbank_r),
    .addr     (wr_ptr_r),
    .data     (in_data),
`ifdef SFB_FLUSH_EN
    .pad_en   (flush_go_s && wbank_r),
    .pad_from (pad_from_s),
`endif
    .q        (bank_b_q_s)
  );

  // Write pointer: advances per transfer, returns to 0 when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
    end else if (fill_s) begin
      wr_ptr_r <= PTR_ZERO;
    end else if (xfer_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Bank select and full flags; swap and fill are mutually exclusive
  // because a fill needs the write bank not full and a swap needs it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_r <= 1'b0;
      full_r  <= 2'b00;
    end else if (swap_s) begin
      wbank_r          <= !wbank_r;
      full_r[!wbank_r] <= 1'b0;
    end else if (fill_s) begin
      full_r[wbank_r] <= 1'b1;
    end else begin
      full_r <= full_r;
    end
  end

  // Hold counter, start pulse and launch count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r  <= HOLD_ZERO;
      start_r     <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      start_r <= swap_s;
      if (swap_s) begin
        hold_cnt_r  <= HOLD_LOAD;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else if (hold_cnt_r != HOLD_ZERO) begin
        hold_cnt_r <= hold_cnt_r - HOLD_ONE;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign start_flg = start_r;
  assign frame_cnt = frame_cnt_r;
  // Presented bank is always the one not being written; nothing writes it,
  // so frame_o only changes on the swap edge.
  assign frame_o   = wbank_r ? bank_a_q_s : bank_b_q_s;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer: two instances (HOLD_CYC 4 and 300)
// driven by directed streams; accepted samples feed a reference frame model
// whose completed frames are queued and popped by a monitor on each start_flg.
module tb_sample_frame_buffer;
  import sfb_pkg::*;

  localparam int HOLD0 = 4;
  localparam int HOLD1 = 300;

  typedef struct packed {
    frame_t      f;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  sample_t     dat [2];
  logic        rdy [2];
  logic        stf [2];
  frame_t      fro [2];
  logic [15:0] fcnt [2];
`ifdef SFB_FLUSH_EN
  logic        fl [2];
`endif

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int stalls [2];

  exp_t        q0 [$];
  exp_t        q1 [$];
  frame_t      mfr [2];
  int          mptr [2];
  logic [15:0] mcnt [2];

  frame_t held [2];
  logic   have_held [2];
  logic   have_pulse [2];
  int     pulse_cyc [2];
  int     prev_pulse_cyc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_frame_buffer #(.HOLD_CYC(HOLD0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .start_flg(stf[0]), .frame_o(fro[0]), .frame_cnt(fcnt[0])
`ifdef SFB_FLUSH_EN
    , .flush(fl[0])
`endif
  );

  sample_frame_buffer #(.HOLD_CYC(HOLD1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .start_flg(stf[1]), .frame_o(fro[1]), .frame_cnt(fcnt[1])
`ifdef SFB_FLUSH_EN
    , .flush(fl[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
    int bad;
    bad = -1;
    for (int i = FRAME_LEN - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    checks++;
    if (bad < 0) passed++;
    else $display("FAIL %s: index %0d got %0h expected %0h (t=%0t)",
                  name, bad, act[bad], exp[bad], $time);
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? HOLD0 : HOLD1;
  endfunction

  task automatic model_launch(input int d);
    exp_t e;
    mcnt[d] = mcnt[d] + 16'd1;
    e.f = mfr[d];
    e.c = mcnt[d];
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    mptr[d] = 0;
  endtask

  task automatic model_accept(input int d, input sample_t v);
    mfr[d][mptr[d]] = v;
    mptr[d]++;
    if (mptr[d] == FRAME_LEN) model_launch(d);
  endtask

  // Called at a negedge; returns at the following negedge with valid dropped.
  task automatic send(input int d, input sample_t v);
    int n;
    n = 0;
    vld[d] = 1'b1;
    dat[d] = v;
    while (!rdy[d] && n < 2000) begin
      stalls[d]++;
      n++;
      @(negedge clk);
    end
    if (n >= 2000) begin
      chk("send_timeout", {31'd0, rdy[d]}, 32'd1);
    end else begin
      @(posedge clk);
      model_accept(d, v);
    end
    @(negedge clk);
    vld[d] = 1'b0;
  endtask

  task automatic do_reset();
    frame_t zero_f;
    zero_f = {(FRAME_LEN*SAMPLE_W){1'b0}};
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      have_held[d] = 1'b0;
      have_pulse[d] = 1'b0;
      vld[d] = 1'b0;
      mptr[d] = 0;
      mcnt[d] = 16'd0;
`ifdef SFB_FLUSH_EN
      fl[d] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_q0_empty", q0.size(), 32'd0);
    chk("rst_q1_empty", q1.size(), 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", {31'd0, rdy[d]}, 32'd1);
      chk("rst_start", {31'd0, stf[d]}, 32'd0);
      chk("rst_frame_cnt", {16'd0, fcnt[d]}, 32'd0);
      chk_frame("rst_frame_o", fro[d], zero_f);
    end
  endtask

  // Monitor: pops the scoreboard on every start pulse, otherwise checks
  // that the presented frame has not moved.
  task automatic mon(input int d);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (stf[d]) begin
      if (qs == 0) begin
        chk("unexpected_start", {31'd0, stf[d]}, 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk_frame("frame_data", fro[d], e.f);
        chk("frame_cnt", {16'd0, fcnt[d]}, {16'd0, e.c});
      end
      if (have_pulse[d])
        chk("pulse_spacing_ge_hold", {31'd0, (cyc - pulse_cyc[d]) >= hold_of(d)}, 32'd1);
      prev_pulse_cyc[d] = pulse_cyc[d];
      pulse_cyc[d] = cyc;
      have_pulse[d] = 1'b1;
      held[d] = fro[d];
      have_held[d] = 1'b1;
    end else if (have_held[d]) begin
      chk_frame("frame_stable", fro[d], held[d]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0;
      dat[d] = 8'h00;
      stalls[d] = 0;
      mfr[d] = {(FRAME_LEN*SAMPLE_W){1'b0}};
      pulse_cyc[d] = 0;
      prev_pulse_cyc[d] = 0;
    end
    do_reset();

    // Test 1: one frame of value=i at full rate.
    stalls[0] = 0;
    for (int i = 0; i < 256; i++) send(0, 8'(i));
    chk("t1_no_stall_in_frame", stalls[0], 32'd0);
    chk("t1_ready_low_after_last", {31'd0, rdy[0]}, 32'd0);
    chk("t1_start_not_yet", {31'd0, stf[0]}, 32'd0);
    @(negedge clk);
    chk("t1_start_edge_n_plus_1", {31'd0, stf[0]}, 32'd1);
    chk("t1_ready_back", {31'd0, rdy[0]}, 32'd1);
    chk("t1_frame_o_255", {24'd0, fro[0][255]}, 32'd255);
    chk("t1_frame_cnt", {16'd0, fcnt[0]}, 32'd1);
    repeat (5) @(negedge clk);

    // Test 2: 512 back-to-back samples, value (3i+1) mod 256.
    stalls[0] = 0;
    for (int i = 0; i < 512; i++) send(0, 8'(i * 3 + 1));
    repeat (3) @(negedge clk);
    chk("t2_one_stall", stalls[0], 32'd1);
    chk("t2_pulse_gap", pulse_cyc[0] - prev_pulse_cyc[0], 32'd257);
    chk("t2_frame_cnt", {16'd0, fcnt[0]}, 32'd3);
    chk("t2_frame_o_0", {24'd0, fro[0][0]}, 32'd1);      // 256*3+1 = 769 -> 1
    chk("t2_frame_o_255", {24'd0, fro[0][255]}, 32'd254); // 511*3+1 = 1534 -> 254

    // Test 3: HOLD_CYC=300; sample 512 is held off until the hold expires.
    stalls[1] = 0;
    for (int i = 0; i < 513; i++) send(1, 8'(i + 100));
    repeat (3) @(negedge clk);
    chk("t3_stall_cycles", stalls[1], 32'd46);
    chk("t3_pulse_gap", pulse_cyc[1] - prev_pulse_cyc[1], 32'd301);
    chk("t3_frame_cnt", {16'd0, fcnt[1]}, 32'd2);

    // Test 4: random gaps over three frames.
    do_reset();
    for (int i = 0; i < 768; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(0, 8'($urandom));
    end
    repeat (5) @(negedge clk);
    chk("t4_frame_cnt", {16'd0, fcnt[0]}, 32'd3);

    // Test 5: reset mid-frame discards the partial frame.
    for (int i = 0; i < 100; i++) send(0, 8'hAA);
    do_reset();
    for (int i = 0; i < 256; i++) send(0, 8'(255 - i));
    repeat (3) @(negedge clk);
    chk("t5_frame_cnt", {16'd0, fcnt[0]}, 32'd1);
    chk("t5_frame_o_0", {24'd0, fro[0][0]}, 32'd255);
    chk("t5_frame_o_99", {24'd0, fro[0][99]}, 32'd156);

`ifdef SFB_FLUSH_EN
    // Test 6: flush a 10-sample partial frame, then flush an empty bank.
    for (int i = 0; i < 10; i++) send(0, 8'hFF);
    fl[0] = 1'b1;
    for (int i = mptr[0]; i < FRAME_LEN; i++) mfr[0][i] = 8'h00;
    model_launch(0);
    @(negedge clk);
    fl[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_frame_cnt", {16'd0, fcnt[0]}, 32'd2);
    chk("t6_frame_o_9", {24'd0, fro[0][9]}, 32'hFF);
    chk("t6_frame_o_10", {24'd0, fro[0][10]}, 32'h00);
    fl[0] = 1'b1;
    @(negedge clk);
    fl[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_empty_flush_ignored", {16'd0, fcnt[0]}, 32'd2);
`endif

    repeat (5) @(negedge clk);
    chk("end_q0_drained", q0.size(), 32'd0);
    chk("end_q1_drained", q1.size(), 32'd0);
    chk("end_cnt0", {16'd0, fcnt[0]}, {16'd0, mcnt[0]});
    chk("end_cnt1", {16'd0, fcnt[1]}, {16'd0, mcnt[1]});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
